// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: merges stage hold
// requests into a thermometer stall bus, handles redirects, stale fetches and MEM timeouts.
module pipe_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic        if_ack,
  input  logic        id_load_use,
  input  logic        ex_busy,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [5:0]  stall,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        if_kill,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  localparam logic [8:0] TIMEOUT   = 9'(MEM_TIMEOUT);
  localparam logic [5:0] STALL_NONE = 6'h00;
  localparam logic [5:0] STALL_IF   = 6'h03;
  localparam logic [5:0] STALL_ID   = 6'h07;
  localparam logic [5:0] STALL_EX   = 6'h0F;
  localparam logic [5:0] STALL_MEM  = 6'h1F;

  logic       lu_done;
  logic       if_discard;
  logic [8:0] mem_wait_cnt;
  logic [8:0] mem_wait_cnt_next;

  logic mem_wait;
  logic if_wait;
  logic lu_req;
  logic discard_hit;
  logic redirect_ok;

  always_comb begin
    mem_wait    = mem_req && !mem_ack;
    if_wait     = if_req && !if_ack;
    lu_req      = id_load_use && !lu_done;
    discard_hit = if_discard && if_ack;
    // stall[3] is set only by MEM wait or ex_busy, so test those directly
    redirect_ok = ex_redirect && !(mem_wait || ex_busy);
  end

  // An accepted redirect overrides every lower request so the PC loads the target
  always_comb begin
    stall = STALL_NONE;
    if (mem_wait)                        stall = STALL_MEM;
    else if (ex_busy)                    stall = STALL_EX;
    else if (redirect_ok)                stall = STALL_NONE;
    else if (lu_req)                     stall = STALL_ID;
    else if (if_wait || discard_hit)     stall = STALL_IF;
  end

  always_comb begin
    flush_if_id = redirect_ok;
    flush_id_ex = redirect_ok;
    if_kill     = if_discard;
  end

  always_comb begin
    mem_wait_cnt_next = '0;
    if (mem_wait) begin
      mem_wait_cnt_next = (mem_wait_cnt >= TIMEOUT) ? TIMEOUT : mem_wait_cnt + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_done      <= 1'b0;
      if_discard   <= 1'b0;
      mem_wait_cnt <= '0;
      mem_err      <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (stall == STALL_ID)  lu_done <= 1'b1;
      else if (!stall[2])     lu_done <= 1'b0;

      if (redirect_ok && if_wait) if_discard <= 1'b1;
      else if (discard_hit)       if_discard <= 1'b0;

      mem_wait_cnt <= mem_wait_cnt_next;
      if (mem_wait && mem_wait_cnt_next == TIMEOUT) mem_err <= 1'b1;

      if (stall[0]) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. Collects hold requests from the IF, ID, EX and MEM stages and drives the 6-bit `stall` bus that every inter-stage register consumes. Also drives branch-redirect flushes and discards stale instruction fetches. It tracks load-use bubbles and data-memory wait time, and counts stall cycles.

## Interface
- `MEM_TIMEOUT`, default 256: consecutive data-memory wait cycles before `mem_err` sets.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  IF has a fetch outstanding.
- `if_ack`  in  1  instruction memory returns fetch data this cycle.
- `id_load_use`  in  1  ID instruction depends on a load currently in EX.
- `ex_busy`  in  1  multi-cycle EX unit is not done.
- `ex_redirect`  in  1  EX resolved a taken branch or jump; target is valid this cycle.
- `mem_req`  in  1  MEM has a data access outstanding.
- `mem_ack`  in  1  data memory completes the access this cycle.
- `stall`  out  6  per-stage hold; bit 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
- `flush_if_id`  out  1  clear the IF/ID register this cycle.
- `flush_id_ex`  out  1  clear the ID/EX register this cycle.
- `if_kill`  out  1  the next `if_ack` data is stale; the fetch unit drops it.
- `mem_err`  out  1  sticky data-memory timeout flag.
- `stall_cnt`  out  32  count of cycles with `stall[0]`=1.

## Operation
- **Stall encoding.** `stall[k:0]`=1 and `stall[5:k+1]`=0, where k is the highest stalling stage.
  - The register after stage k sees `stall[k]&&!stall[k+1]` and inserts a bubble.
  - Legal values: 0x00, 0x03, 0x07, 0x0F, 0x1F. 0x3F is never driven.
- **Requests, highest k wins:**
  - MEM wait (`mem_req&&!mem_ack`): k=4.
  - `ex_busy`: k=3.
  - Load-use, when the stall is armed: k=2.
  - IF wait (`if_req&&!if_ack`), or a discard hit: k=1.
- **Load-use.** Gives exactly one bubble per dependent instruction.
  - State bit `lu_done`. The load-use request is armed when `id_load_use&&!lu_done`.
  - `lu_done` sets at the edge ending a cycle with `stall`=0x07.
  - `lu_done` clears at any edge where `stall[2]`=0, i.e. ID advanced.
  - If a higher stall hides the load-use cycle, `lu_done` stays 0 and the bubble still happens later.
- **Redirect.** Accepted only when `ex_redirect&&!stall[3]`. When accepted:
  - `flush_if_id`=`flush_id_ex`=1.
  - The load-use and IF-wait requests are ignored that cycle, so `stall`=0x00 and the PC loads the target.
- When `ex_redirect` is high but `stall[3]`=1: no flush. EX holds and re-presents the redirect later.
- **Fetch discard.**
  - State bit `if_discard` sets on an accepted redirect when `if_req&&!if_ack` (fetch in flight).
  - While `if_discard`=1: `if_kill`=1.
  - A cycle with `if_ack` is a discard hit: k≥1, so IF holds. `if_discard` clears at that edge.
- **Memory timeout.**
  - 9-bit `mem_wait_cnt` increments on each MEM-wait cycle, saturating at `MEM_TIMEOUT`. It clears on any cycle without MEM wait.
  - `mem_err` sets when the count reaches `MEM_TIMEOUT`, and holds until reset.
  - The stall itself is unaffected by the timeout.
- **Stall counter.** `stall_cnt` increments by 1 each cycle with `stall[0]`=1 and wraps 0xFFFFFFFF→0.

## Timing
- `stall`, `flush_*` and `if_kill` are combinational from the inputs plus state registers, valid in the same cycle. No input-to-output latency.
- State (`lu_done`, `if_discard`, `mem_wait_cnt`, `mem_err`, `stall_cnt`) updates on the rising edge of `clk`.
- Reset (asynchronous): all state goes to 0. With idle inputs the outputs are `stall`=0x00, flushes=0, `if_kill`=0, `mem_err`=0, `stall_cnt`=0.
- Reset mid-stall clears `if_discard` and `lu_done`. The first post-reset cycle re-evaluates requests from scratch.
- Same cycle `mem_req&&mem_ack`: not a wait; the counter clears.
- An accepted redirect in the same cycle as `if_ack` does not set `if_discard`, because that data is killed by `flush_if_id`.

## Test plan
- **Load-use single bubble.** `id_load_use`=1 held 2 cycles, others idle → `stall`=0x07 in cycle 1, 0x00 in cycle 2. `lu_done` is 1 after cycle 1 and 0 after cycle 2.
- **MEM wait over load-use.** `mem_req`=1 with `mem_ack`=0 for 3 cycles plus `id_load_use`=1 → `stall`=0x1F for 3 cycles. Once `mem_ack`=1, `stall`=0x07 for one cycle, then 0x00. `stall_cnt`=4.
- **Redirect with fetch in flight.** `ex_redirect`=1, `if_req`=1, `if_ack`=0 → flushes=1 and `stall`=0x00 that cycle. `if_kill`=1 afterwards. On the next `if_ack`, `stall`=0x03; `if_kill` drops the following cycle.
- **Blocked redirect.** `ex_redirect`=1 and `ex_busy`=1 → `stall`=0x0F, no flush. `ex_busy` drops with `ex_redirect` still 1 → flushes=1.
- **Timeout.** `MEM_TIMEOUT`=4, `mem_req`=1, `mem_ack`=0 for 6 cycles → `mem_err` rises after the 4th edge and stays 1 after `mem_ack`. An async `rst_n` pulse clears it without waiting for a clock edge.
- **Wrap.** Preload `stall_cnt`=0xFFFFFFFF via force, then one stall cycle → 0x00000000.
